// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus iterative unsigned
// multiply and restoring divide, fronted by a start/done handshake.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             cout,
  output logic             ovf,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLTU = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    count;
  logic             is_div;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             accept_sc;
  logic             accept_mc;
  logic             finish;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] sc_result;
  logic             sc_cout;
  logic             sc_ovf;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;

  assign busy = (state == RUN);

  // Combinational result of every single-cycle op, registered on accept
  always_comb begin
    add_full  = {1'b0, A} + {1'b0, B};
    sub_full  = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
    sc_result = '0;
    sc_cout   = 1'b0;
    sc_ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        sc_result = add_full[WIDTH-1:0];
        sc_cout   = add_full[WIDTH];
        sc_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = sub_full[WIDTH-1:0];
        sc_cout   = sub_full[WIDTH];
        sc_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (sub_full[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_AND:  sc_result = A & B;
      OP_OR:   sc_result = A | B;
      OP_XOR:  sc_result = A ^ B;
      OP_NOR:  sc_result = ~(A | B);
      default: sc_result = '0;
    endcase
  end

  // One multiply or divide step; acc_hi/acc_lo hold product or remainder/quotient
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, operand};
    hi_nxt    = mul_sum[WIDTH:1];
    lo_nxt    = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      if (!div_trial[WIDTH]) begin
        hi_nxt = div_trial[WIDTH-1:0];
        lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = div_shift[WIDTH-1:0];
        lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Start is only looked at in IDLE, so requests while busy are dropped
  always_comb begin
    state_nxt = state;
    accept_sc = 1'b0;
    accept_mc = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (op == OP_MULU || op == OP_DIVU) begin
            accept_mc = 1'b1;
            state_nxt = RUN;
          end else begin
            accept_sc = 1'b1;
          end
        end
      end
      RUN: begin
        if (count == CW'(WIDTH-1)) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      is_div      <= 1'b0;
      operand     <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      result      <= '0;
      result_hi   <= '0;
      zero        <= 1'b0;
      cout        <= 1'b0;
      ovf         <= 1'b0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_sc) begin
        result      <= sc_result;
        result_hi   <= '0;
        zero        <= (sc_result == '0);
        cout        <= sc_cout;
        ovf         <= sc_ovf;
        div_by_zero <= 1'b0;
        done        <= 1'b1;
      end
      // Multiply keeps A as the addend and shifts B out; divide shifts A into the remainder
      if (accept_mc) begin
        is_div  <= (op == OP_DIVU);
        operand <= (op == OP_MULU) ? A : B;
        acc_lo  <= (op == OP_MULU) ? B : A;
        acc_hi  <= '0;
        count   <= '0;
      end
      if (state == RUN) begin
        acc_hi <= hi_nxt;
        acc_lo <= lo_nxt;
        count  <= count + CW'(1);
      end
      if (finish) begin
        result      <= lo_nxt;
        result_hi   <= hi_nxt;
        zero        <= (lo_nxt == '0);
        cout        <= 1'b0;
        ovf         <= 1'b0;
        div_by_zero <= is_div && (operand == '0);
        done        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=8): vector table plus hand-written
// sequences for busy-time start, back-to-back ops and mid-op reset.
module tb_alu_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic       zero;
  logic       cout;
  logic       ovf;
  logic       div_by_zero;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] hi;
    logic       z;
    logic       c;
    logic       v;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
    .result(result), .result_hi(result_hi), .zero(zero), .cout(cout),
    .ovf(ovf), .div_by_zero(div_by_zero), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string n, input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] r, input logic [7:0] h, input logic z, input logic c,
                         input logic v, input logic dz, input int lat);
    vec_t t;
    t.name = n; t.op = o; t.a = va; t.b = vb; t.res = r; t.hi = h;
    t.z = z; t.c = c; t.v = v; t.dz = dz; t.lat = lat;
    vecs.push_back(t);
  endtask

  // Issue one op, scramble operands afterwards, wait for done and return latency
  task automatic issue_and_wait(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                                input int pulse_at, output int cycles);
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0; op = 4'hF; a = ~va; b = ~vb;
    cycles = 1;
    while (!done && cycles < 40) begin
      if (cycles == pulse_at) begin
        start = 1'b1; op = 4'b0000; a = 8'h01; b = 8'h01;
      end
      @(negedge clk);
      start = 1'b0;
      cycles++;
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    int cycles;
    issue_and_wait(v.op, v.a, v.b, 0, cycles);
    check_output({v.name, " latency"}, cycles, v.lat);
    check_output({v.name, " done"}, done, 1'b1);
    check_output({v.name, " busy@done"}, busy, 1'b0);
    check_output({v.name, " result"}, result, v.res);
    check_output({v.name, " result_hi"}, result_hi, v.hi);
    check_output({v.name, " zero"}, zero, v.z);
    check_output({v.name, " cout"}, cout, v.c);
    check_output({v.name, " ovf"}, ovf, v.v);
    check_output({v.name, " div_by_zero"}, div_by_zero, v.dz);
    @(negedge clk);
    check_output({v.name, " done pulse"}, done, 1'b0);
  endtask

  initial begin
    int cycles;
    int done_seen;

    reset = 1'b1; start = 1'b0; op = 4'h0; a = 8'h00; b = 8'h00;

    //       name          op       A      B      res    hi    z  c  v  dz lat
    add_vec("ADD F0+20",  4'b0000, 8'hF0, 8'h20, 8'h10, 8'h00, 0, 1, 0, 0, 1);
    add_vec("SUB 80-01",  4'b0010, 8'h80, 8'h01, 8'h7F, 8'h00, 0, 1, 1, 0, 1);
    add_vec("SLT 80,01",  4'b0011, 8'h80, 8'h01, 8'h01, 8'h00, 0, 0, 0, 0, 1);
    add_vec("SLTU 80,01", 4'b0001, 8'h80, 8'h01, 8'h00, 8'h00, 1, 0, 0, 0, 1);
    add_vec("SUB 55-55",  4'b0010, 8'h55, 8'h55, 8'h00, 8'h00, 1, 1, 0, 0, 1);
    add_vec("AND",        4'b0100, 8'hCC, 8'hAA, 8'h88, 8'h00, 0, 0, 0, 0, 1);
    add_vec("OR",         4'b0101, 8'hCC, 8'hAA, 8'hEE, 8'h00, 0, 0, 0, 0, 1);
    add_vec("XOR",        4'b0110, 8'hCC, 8'hAA, 8'h66, 8'h00, 0, 0, 0, 0, 1);
    add_vec("NOR",        4'b0111, 8'hCC, 8'hAA, 8'h11, 8'h00, 0, 0, 0, 0, 1);
    add_vec("ADD 7F+01",  4'b0000, 8'h7F, 8'h01, 8'h80, 8'h00, 0, 0, 1, 0, 1);
    add_vec("SUB 00-01",  4'b0010, 8'h00, 8'h01, 8'hFF, 8'h00, 0, 0, 0, 0, 1);
    add_vec("SLT 01,80",  4'b0011, 8'h01, 8'h80, 8'h00, 8'h00, 1, 0, 0, 0, 1);
    add_vec("MULU FFxFF", 4'b1000, 8'hFF, 8'hFF, 8'h01, 8'hFE, 0, 0, 0, 0, 9);
    add_vec("UNDEF op",   4'b1111, 8'h12, 8'h34, 8'h00, 8'h00, 1, 0, 0, 0, 1);
    add_vec("DIVU 200/7", 4'b1001, 8'd200, 8'd7, 8'd28, 8'd4, 0, 0, 0, 0, 9);
    add_vec("MULU 0Dx0B", 4'b1000, 8'h0D, 8'h0B, 8'h8F, 8'h00, 0, 0, 0, 0, 9);
    add_vec("DIVU 3C/0",  4'b1001, 8'h3C, 8'h00, 8'hFF, 8'h3C, 0, 0, 0, 1, 9);
    add_vec("DIVU 05/09", 4'b1001, 8'h05, 8'h09, 8'h00, 8'h05, 1, 0, 0, 0, 9);

    repeat (2) @(negedge clk);
    check_output("reset result", result, 8'h00);
    check_output("reset done", done, 1'b0);
    check_output("reset busy", busy, 1'b0);
    reset = 1'b0;

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // ADD start pulsed while MULU is busy must be dropped
    issue_and_wait(4'b1000, 8'hFF, 8'hFF, 4, cycles);
    check_output("ignored start latency", cycles, 9);
    check_output("ignored start result", result, 8'h01);
    check_output("ignored start result_hi", result_hi, 8'hFE);
    @(negedge clk);
    check_output("ignored start no extra done", done, 1'b0);
    check_output("ignored start busy", busy, 1'b0);

    // AND issued in the MULU done cycle completes one cycle later
    issue_and_wait(4'b1000, 8'h03, 8'h05, 0, cycles);
    check_output("b2b mul latency", cycles, 9);
    check_output("b2b mul result", result, 8'h0F);
    start = 1'b1; op = 4'b0100; a = 8'hF0; b = 8'h3C;
    @(negedge clk);
    start = 1'b0; a = 8'h00; b = 8'h00;
    check_output("b2b and done", done, 1'b1);
    check_output("b2b and result", result, 8'h30);
    check_output("b2b and result_hi", result_hi, 8'h00);
    repeat (3) @(negedge clk);
    check_output("hold result", result, 8'h30);
    check_output("hold done", done, 1'b0);

    // Reset in the middle of a multiply aborts it without a done
    @(negedge clk);
    start = 1'b1; op = 4'b1000; a = 8'h12; b = 8'h34;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_output("pre-reset busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_output("mid reset busy", busy, 1'b0);
    check_output("mid reset result", result, 8'h00);
    check_output("mid reset result_hi", result_hi, 8'h00);
    check_output("mid reset done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check_output("no done after reset", done_seen, 0);
    issue_and_wait(4'b0000, 8'h12, 8'h34, 0, cycles);
    check_output("post reset latency", cycles, 1);
    check_output("post reset result", result, 8'h46);
    issue_and_wait(4'b1000, 8'h12, 8'h34, 0, cycles);
    check_output("post reset mul latency", cycles, 9);
    check_output("post reset mul result", result, 8'hA8);
    check_output("post reset mul result_hi", result_hi, 8'h03);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
